// File: rtl/axil_sram_resp.sv
// axil_sram_resp: AXI-Lite responder backed by a word-addressed SRAM, fixed response latency, DECERR off-range
//  ports: clk_i/rst_i (sync, active-high); ar*/r* read channels; aw*/w*/b* write channels
//  optional AXIL_SRAM_RAND_DELAY_EN: LFSR-driven extra latency (0..3) and ready masking
module axil_sram_resp #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_LATENCY = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_WIDTH-1:0]   araddr_i,
  input  logic                    arvalid_i,
  output logic                    arready_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [1:0]              rresp_o,
  output logic                    rvalid_o,
  input  logic                    rready_i,
  input  logic [ADDR_WIDTH-1:0]   awaddr_i,
  input  logic                    awvalid_i,
  output logic                    awready_o,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH/8-1:0] wstrb_i,
  input  logic                    wvalid_i,
  output logic                    wready_o,
  output logic [1:0]              bresp_o,
  output logic                    bvalid_o,
  input  logic                    bready_i
);
  localparam int IW = $clog2(DEPTH);
  localparam int SW = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH-1:0] SPAN = ADDR_WIDTH'(DEPTH * 4);
  localparam logic [4:0] RL = 5'(READ_LATENCY);
  localparam logic [4:0] WL = 5'(WRITE_LATENCY);
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  r_state_t rs;
  w_state_t ws;
  logic [4:0] rcnt, wcnt, rlat, wlat;
  logic [1:0] rx, wx;
  logic stall;
  logic [ADDR_WIDTH-1:0] ra_q, wa_q, rsel, wa, roff, woff;
  logic [DATA_WIDTH-1:0] wd_q, wd;
  logic [SW-1:0] wm_q, wm;
  logic aw_got, w_got, ar_fire, aw_fire, w_fire, aw_n, w_n, both, rin, win, rload, commit;
`ifdef AXIL_SRAM_RAND_DELAY_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk_i)
    if (rst_i) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  assign rx = lfsr[1:0];
  assign wx = lfsr[1:0];
  assign stall = lfsr[2];
`else
  assign rx = 2'd0;
  assign wx = 2'd0;
  assign stall = 1'b0;
`endif
  assign arready_o = rs == R_IDLE && !stall;
  assign awready_o = ws == W_IDLE && !aw_got && !stall;
  assign wready_o = ws == W_IDLE && !w_got && !stall;
  assign ar_fire = arvalid_i && arready_o;
  assign aw_fire = awvalid_i && awready_o;
  assign w_fire = wvalid_i && wready_o;
  assign aw_n = aw_got || aw_fire;
  assign w_n = w_got || w_fire;
  assign both = ws == W_IDLE && aw_n && w_n;
  assign rlat = RL + {3'd0, rx};
  assign wlat = WL + {3'd0, wx};
  // Same-cycle beats bypass the holding registers so zero latency can commit immediately.
  assign rsel = rs == R_IDLE ? araddr_i : ra_q;
  assign wa = aw_fire ? awaddr_i : wa_q;
  assign wd = w_fire ? wdata_i : wd_q;
  assign wm = w_fire ? wstrb_i : wm_q;
  assign roff = rsel - BASE_ADDR;
  assign woff = wa - BASE_ADDR;
  assign rin = roff < SPAN;
  assign win = woff < SPAN;
  assign rload = (rs == R_IDLE && ar_fire && rlat == 5'd0) || (rs == R_WAIT && rcnt == 5'd1);
  // A reset on the commit edge drops the write entirely.
  assign commit = !rst_i && ((both && wlat == 5'd0) || (ws == W_WAIT && wcnt == 5'd1));
  always_ff @(posedge clk_i)
    if (rst_i) begin
      rs <= R_IDLE;
      rcnt <= '0;
      ra_q <= '0;
      rvalid_o <= 1'b0;
      rdata_o <= '0;
      rresp_o <= 2'b00;
    end else begin
      case (rs)
        R_IDLE: if (ar_fire) begin
          ra_q <= araddr_i;
          rcnt <= rlat;
          rs <= rlat == 5'd0 ? R_RESP : R_WAIT;
        end
        R_WAIT: begin
          rcnt <= rcnt - 5'd1;
          if (rcnt == 5'd1) rs <= R_RESP;
        end
        R_RESP: if (rready_i) rs <= R_IDLE;
        default: rs <= R_IDLE;
      endcase
      if (rload) begin
        rvalid_o <= 1'b1;
        rdata_o <= rin ? mem[roff[IW+1:2]] : '0;
        rresp_o <= rin ? 2'b00 : 2'b11;
      end else if (rready_i) rvalid_o <= 1'b0;
    end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      ws <= W_IDLE;
      wcnt <= '0;
      aw_got <= 1'b0;
      w_got <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
      wm_q <= '0;
      bvalid_o <= 1'b0;
      bresp_o <= 2'b00;
    end else begin
      if (aw_fire) wa_q <= awaddr_i;
      if (w_fire) begin
        wd_q <= wdata_i;
        wm_q <= wstrb_i;
      end
      case (ws)
        W_IDLE: begin
          aw_got <= aw_n;
          w_got <= w_n;
          if (both) begin
            wcnt <= wlat;
            ws <= wlat == 5'd0 ? W_RESP : W_WAIT;
          end
        end
        W_WAIT: begin
          wcnt <= wcnt - 5'd1;
          if (wcnt == 5'd1) ws <= W_RESP;
        end
        W_RESP: if (bready_i) begin
          ws <= W_IDLE;
          aw_got <= 1'b0;
          w_got <= 1'b0;
        end
        default: ws <= W_IDLE;
      endcase
      if (commit) begin
        bvalid_o <= 1'b1;
        bresp_o <= win ? 2'b00 : 2'b11;
      end else if (bready_i) bvalid_o <= 1'b0;
    end
  always_ff @(posedge clk_i)
    if (commit && win)
      for (int b = 0; b < SW; b++)
        if (wm[b]) mem[woff[IW+1:2]][8*b +: 8] <= wd[8*b +: 8];
endmodule

// File: tb/tb_axil_sram_resp.sv
// tb_axil_sram_resp: directed vector table plus hand sequences for axil_sram_resp
module tb_axil_sram_resp;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0, rdata;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0] wstrb = '0;
  logic arready, rvalid, awready, wready, bvalid;
  logic [1:0] rresp, bresp;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  axil_sram_resp dut (
    .clk_i(clk), .rst_i(rst),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready)
  );
  typedef struct {
    bit wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0] strb;
    logic [31:0] exp_data;
    logic [1:0] exp_resp;
  } vec_t;
  vec_t v[13];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic axw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic [1:0] resp, output int lat);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; lat = 1;
    while (!bvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    resp = bresp; bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask
  task automatic axr(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                     output int lat);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0; lat = 1;
    while (!rvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = rdata; resp = rresp; rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
  endtask
  initial begin
    logic [31:0] d;
    logic [1:0] r;
    int lat;
    v[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, 2'b00};
    v[1]  = '{1'b0, 32'h8000_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 2'b00};
    v[2]  = '{1'b1, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, 32'h0, 2'b00};
    v[3]  = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 2'b00};
    v[4]  = '{1'b1, 32'h8000_1000, 32'h1234_5678, 4'hF, 32'h0, 2'b11};
    v[5]  = '{1'b0, 32'h8000_0000, 32'h0, 4'h0, 32'h0BAD_F00D, 2'b00};
    v[6]  = '{1'b0, 32'h8000_1000, 32'h0, 4'h0, 32'h0, 2'b11};
    v[7]  = '{1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 32'h0, 2'b11};
    v[8]  = '{1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00};
    v[9]  = '{1'b1, 32'h8000_0FFC, 32'hFFFF_FFFF, 4'h0, 32'h0, 2'b00};
    v[10] = '{1'b0, 32'h8000_0FFF, 32'h0, 4'h0, 32'hCAFE_F00D, 2'b00};
    v[11] = '{1'b1, 32'h8000_0FFC, 32'h0000_1234, 4'h3, 32'h0, 2'b00};
    v[12] = '{1'b0, 32'h8000_0FFC, 32'h0, 4'h0, 32'hCAFE_1234, 2'b00};
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst arready", 32'(arready), 32'd1);
    chk("rst awready", 32'(awready), 32'd1);
    chk("rst wready", 32'(wready), 32'd1);
    chk("rst rvalid", 32'(rvalid), 32'd0);
    chk("rst bvalid", 32'(bvalid), 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst resp", {28'd0, rresp, bresp}, 32'd0);
    for (int i = 0; i < 13; i++) begin
      if (v[i].wr) begin
        axw(v[i].addr, v[i].data, v[i].strb, r, lat);
        chk($sformatf("v%0d bresp", i), 32'(r), 32'(v[i].exp_resp));
        chk($sformatf("v%0d blat", i), 32'(lat), 32'd2);
      end else begin
        axr(v[i].addr, d, r, lat);
        chk($sformatf("v%0d rdata", i), d, v[i].exp_data);
        chk($sformatf("v%0d rresp", i), 32'(r), 32'(v[i].exp_resp));
        chk($sformatf("v%0d rlat", i), 32'(lat), 32'd2);
      end
    end
    @(negedge clk);
    wdata = 32'h00AB_0000; wstrb = 4'b0100; wvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wvalid = 1'b0;
      chk($sformatf("early w wready %0d", i), 32'(wready), 32'd0);
      chk($sformatf("early w awready %0d", i), 32'(awready), 32'd1);
      chk($sformatf("early w bvalid %0d", i), 32'(bvalid), 32'd0);
    end
    awaddr = 32'h8000_0010; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; lat = 1;
    while (!bvalid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("late aw blat", 32'(lat), 32'd2);
    chk("late aw bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    axr(32'h8000_0010, d, r, lat);
    chk("strb merge", d, 32'hDEAB_BEEF);
    @(negedge clk);
    araddr = 32'h8000_0000; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    chk("stall rvalid on", 32'(rvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("stall rvalid %0d", i), 32'(rvalid), 32'd1);
      chk($sformatf("stall rdata %0d", i), rdata, 32'h0BAD_F00D);
      chk($sformatf("stall arready %0d", i), 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("release rvalid", 32'(rvalid), 32'd0);
    chk("release arready", 32'(arready), 32'd1);
    axw(32'h8000_0020, 32'h1111_1111, 4'hF, r, lat);
    @(negedge clk);
    awaddr = 32'h8000_0020; wdata = 32'h2222_2222; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; araddr = 32'h8000_0020; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    chk("coll rvalid", 32'(rvalid), 32'd1);
    chk("coll bvalid", 32'(bvalid), 32'd1);
    chk("coll old data", rdata, 32'h1111_1111);
    rready = 1'b1; bready = 1'b1;
    @(negedge clk);
    rready = 1'b0; bready = 1'b0;
    axr(32'h8000_0020, d, r, lat);
    chk("coll new data", d, 32'h2222_2222);
    @(negedge clk);
    awaddr = 32'h8000_0020; wdata = 32'h3333_3333; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid rst readies", {29'd0, arready, awready, wready}, 32'd7);
    chk("mid rst bvalid", 32'(bvalid), 32'd0);
    repeat (3) @(negedge clk);
    chk("mid rst bvalid later", 32'(bvalid), 32'd0);
    axr(32'h8000_0020, d, r, lat);
    chk("mid rst no commit", d, 32'h2222_2222);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
